// File: rtl/execute_pkg.sv
// -----------------------------------------------------------------------------
// execute_pkg
// Shared types for the execute stage and its iterative multiply/divide unit.
//   alu_ctrl_e : single-cycle ALU operation after decode
//   md_op_e    : M-extension operation, encoded exactly as funct3
//   fwd_sel_e  : operand forwarding source select
//   md_state_e : multiply/divide sequencer state
// -----------------------------------------------------------------------------
package execute_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_MEM     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative RV32M/RV64M unit: shift-add multiply and restoring divide share one
// 2*XLEN accumulator and run one step per clock on operand magnitudes; the sign
// is fixed up when the result is presented.
//   clk_i, rst_ni : clock, async active-low reset
//   start         : launch an op (only honoured in IDLE)
//   op, a, b      : operation and operands, latched on launch
//   flush         : abandon any op, back to IDLE
//   hold          : keep the finished result presented (downstream stalled)
//   busy, done    : sequencer in BUSY / DONE
//   result        : finished result, valid while done
// -----------------------------------------------------------------------------
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_step, prod;
    logic [XLEN-1:0]   opnd_q, quo, rem;
    md_op_e            op_q;
    logic              neg_lo_q, neg_hi_q, special_q;

    logic              is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    // Launch-time operand preparation: magnitudes, and the two divide cases
    // whose answer is fixed so the sequencer can skip straight to DONE.
    always_comb begin
        is_div      = op[2];
        sgn_a       = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        sgn_b       = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        neg_a       = sgn_a && a[XLEN-1];
        neg_b       = sgn_b && b[XLEN-1];
        mag_a       = neg_a ? -a : a;
        mag_b       = neg_b ? -b : b;
        div_zero    = is_div && (b == '0);
        div_ovf     = is_div && sgn_b && (a == MIN_VAL) && (b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? a : '1;
        end else begin
            special_res = op[1] ? '0 : a;
        end
    end

    // One iteration: multiply adds the multiplicand when the low multiplier
    // bit is set then shifts right; divide shifts the remainder/quotient pair
    // left and keeps the trial subtraction only when it does not go negative.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_step  = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[2]) begin
            if (div_diff[XLEN]) begin
                acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end
    end

    // Sequencer next state; flush beats everything else.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: if (start) state_d = (div_zero || div_ovf) ? MD_DONE : MD_BUSY;
                MD_BUSY: if (cnt_q == '0) state_d = MD_DONE;
                MD_DONE: if (!hold) state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latches, iteration counter and accumulator. Special-case divides
    // park their fixed answer in the low half of the accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= MD_MUL;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            special_q <= 1'b0;
        end else if (!flush && state_q == MD_IDLE && start) begin
            cnt_q     <= CW'(XLEN-1);
            op_q      <= op;
            neg_lo_q  <= neg_a ^ neg_b;
            neg_hi_q  <= neg_a;
            special_q <= div_zero || div_ovf;
            opnd_q    <= is_div ? mag_b : mag_a;
            if (div_zero || div_ovf) begin
                acc_q <= {{XLEN{1'b0}}, special_res};
            end else begin
                acc_q <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            end
        end else if (!flush && state_q == MD_BUSY) begin
            cnt_q <= cnt_q - CW'(1);
            acc_q <= acc_step;
        end
    end

    // Sign correction and half selection of the finished accumulator.
    always_comb begin
        prod   = neg_lo_q ? -acc_q : acc_q;
        quo    = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem    = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        result = prod[XLEN-1:0];
        if (special_q) begin
            result = acc_q[XLEN-1:0];
        end else begin
            case (op_q)
                MD_MUL:                         result = prod[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU:   result = prod[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:                result = quo;
                default:                        result = rem;
            endcase
        end
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);

endmodule

// File: rtl/execute_stage_md.sv
// -----------------------------------------------------------------------------
// execute_stage_md
// Execute stage with operand forwarding, single-cycle ALU, iterative M unit and
// the EX/MEM pipeline register.
//   clk_i, reset_ni        : clock, async active-low reset (sync release inside)
//   valid_i / ready_o      : ID/EX handshake; ready_o low holds upstream
//   stall_i, flush_i       : MEM back-pressure, kill of the EX instruction
//   *_i control, alu_op_i, funct3_i, funct7_b5_i, funct7_b0_i : decode inputs
//   pc_i, rs1/rs2_data_i, imm_i, rd_i, fwd_a/b_i, wb_data_i   : operands
//   *_mem_o                : EX/MEM register contents
// -----------------------------------------------------------------------------
module execute_stage_md
    import execute_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  mem_to_reg_i,
    input  logic                  mem_write_i,
    input  logic                  mem_read_i,
    input  logic                  reg_write_i,
    input  logic                  branch_i,
    input  logic                  alu_src_i,
    input  logic [1:0]            alu_op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7_b5_i,
    input  logic                  funct7_b0_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [1:0]            fwd_a_i,
    input  logic [1:0]            fwd_b_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic                  valid_mem_o,
    output logic [XLEN-1:0]       alu_result_mem_o,
    output logic [XLEN-1:0]       pc_target_mem_o,
    output logic [XLEN-1:0]       store_data_mem_o,
    output logic                  zero_mem_o,
    output logic [REG_ADDR_W-1:0] rd_mem_o,
    output logic                  mem_to_reg_mem_o,
    output logic                  mem_write_mem_o,
    output logic                  mem_read_mem_o,
    output logic                  reg_write_mem_o,
    output logic                  branch_mem_o
);

    localparam int SHW = $clog2(XLEN);

    logic [1:0]      rst_sync_q;
    logic            rst_n;
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_out, md_result, ex_result;
    logic [SHW-1:0]  shamt;
    alu_ctrl_e       alu_ctrl;
    logic            is_m, md_busy, md_done;

    // Reset asserts immediately but releases on a clock edge so every flop
    // leaves reset in the same cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Forwarding muxes; operand B swaps in the immediate for I-type and loads.
    always_comb begin
        case (fwd_sel_e'(fwd_a_i))
            FWD_MEM: fwd_a = alu_result_mem_o;
            FWD_WB:  fwd_a = wb_data_i;
            default: fwd_a = rs1_data_i;
        endcase
        case (fwd_sel_e'(fwd_b_i))
            FWD_MEM: fwd_b = alu_result_mem_o;
            FWD_WB:  fwd_b = wb_data_i;
            default: fwd_b = rs2_data_i;
        endcase
        op_a = fwd_a;
        op_b = alu_src_i ? imm_i : fwd_b;
    end

    // ALU decode. Only R-type uses funct7 bit 5 to pick SUB; both R and I
    // forms use it to pick the arithmetic right shift.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op_i)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3_i)
                    3'b000:  alu_ctrl = (alu_op_i == 2'b10 && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

    assign shamt = op_b[SHW-1:0];

    // Single-cycle ALU.
    always_comb begin
        case (alu_ctrl)
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SLL:  alu_out = op_a << shamt;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SRL:  alu_out = op_a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_out = op_a | op_b;
            ALU_AND:  alu_out = op_a & op_b;
            default:  alu_out = op_a + op_b;
        endcase
    end

    assign is_m = (alu_op_i == 2'b10) && funct7_b0_i;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk_i  (clk_i),
        .rst_ni (rst_n),
        .start  (valid_i && is_m && !md_busy && !md_done),
        .op     (md_op_e'(funct3_i)),
        .a      (op_a),
        .b      (op_b),
        .flush  (flush_i),
        .hold   (stall_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign ex_result = is_m ? md_result : alu_out;

    // An M op holds upstream until its result is sitting in DONE.
    assign ready_o = !stall_i && !(valid_i && is_m && !md_done);

    // EX/MEM register. Bubbles and flushed slots clear valid and every
    // side-effecting control; their data fields simply keep the old values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_mem_o      <= 1'b0;
            alu_result_mem_o <= '0;
            pc_target_mem_o  <= '0;
            store_data_mem_o <= '0;
            zero_mem_o       <= 1'b0;
            rd_mem_o         <= '0;
            mem_to_reg_mem_o <= 1'b0;
            mem_write_mem_o  <= 1'b0;
            mem_read_mem_o   <= 1'b0;
            reg_write_mem_o  <= 1'b0;
            branch_mem_o     <= 1'b0;
        end else if (flush_i || (!stall_i && !ready_o)) begin
            valid_mem_o      <= 1'b0;
            mem_to_reg_mem_o <= 1'b0;
            mem_write_mem_o  <= 1'b0;
            mem_read_mem_o   <= 1'b0;
            reg_write_mem_o  <= 1'b0;
            branch_mem_o     <= 1'b0;
        end else if (!stall_i) begin
            valid_mem_o      <= valid_i;
            alu_result_mem_o <= ex_result;
            pc_target_mem_o  <= pc_i + imm_i;
            store_data_mem_o <= fwd_b;
            zero_mem_o       <= (ex_result == '0);
            rd_mem_o         <= rd_i;
            mem_to_reg_mem_o <= valid_i && mem_to_reg_i;
            mem_write_mem_o  <= valid_i && mem_write_i;
            mem_read_mem_o   <= valid_i && mem_read_i;
            reg_write_mem_o  <= valid_i && reg_write_i;
            branch_mem_o     <= valid_i && branch_i;
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// -----------------------------------------------------------------------------
// tb_execute_stage_md
// Directed vectors with hand-computed results for execute_stage_md (XLEN=32):
// forwarding, ALU ops, M ops including divide special cases, flush, stall
// across DONE, and asynchronous reset in the middle of an iteration.
// -----------------------------------------------------------------------------
module tb_execute_stage_md;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        valid_i, ready_o, stall_i, flush_i;
    logic        mem_to_reg_i, mem_write_i, mem_read_i, reg_write_i, branch_i, alu_src_i;
    logic [1:0]  alu_op_i;
    logic [2:0]  funct3_i;
    logic        funct7_b5_i, funct7_b0_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i, wb_data_i;
    logic [4:0]  rd_i;
    logic [1:0]  fwd_a_i, fwd_b_i;
    logic        valid_mem_o, zero_mem_o;
    logic [31:0] alu_result_mem_o, pc_target_mem_o, store_data_mem_o;
    logic [4:0]  rd_mem_o;
    logic        mem_to_reg_mem_o, mem_write_mem_o, mem_read_mem_o, reg_write_mem_o, branch_mem_o;

    int checks = 0;
    int errors = 0;

    execute_stage_md #(
        .XLEN(32),
        .REG_ADDR_W(5)
    ) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .mem_to_reg_i     (mem_to_reg_i),
        .mem_write_i      (mem_write_i),
        .mem_read_i       (mem_read_i),
        .reg_write_i      (reg_write_i),
        .branch_i         (branch_i),
        .alu_src_i        (alu_src_i),
        .alu_op_i         (alu_op_i),
        .funct3_i         (funct3_i),
        .funct7_b5_i      (funct7_b5_i),
        .funct7_b0_i      (funct7_b0_i),
        .pc_i             (pc_i),
        .rs1_data_i       (rs1_data_i),
        .rs2_data_i       (rs2_data_i),
        .imm_i            (imm_i),
        .rd_i             (rd_i),
        .fwd_a_i          (fwd_a_i),
        .fwd_b_i          (fwd_b_i),
        .wb_data_i        (wb_data_i),
        .valid_mem_o      (valid_mem_o),
        .alu_result_mem_o (alu_result_mem_o),
        .pc_target_mem_o  (pc_target_mem_o),
        .store_data_mem_o (store_data_mem_o),
        .zero_mem_o       (zero_mem_o),
        .rd_mem_o         (rd_mem_o),
        .mem_to_reg_mem_o (mem_to_reg_mem_o),
        .mem_write_mem_o  (mem_write_mem_o),
        .mem_read_mem_o   (mem_read_mem_o),
        .reg_write_mem_o  (reg_write_mem_o),
        .branch_mem_o     (branch_mem_o)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one ID/EX instruction; called on a falling edge.
    task automatic applyStimulus(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                                 input logic b5, input logic b0, input logic asrc,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        valid_i     = v;
        alu_op_i    = aop;
        funct3_i    = f3;
        funct7_b5_i = b5;
        funct7_b0_i = b0;
        alu_src_i   = asrc;
        fwd_a_i     = fa;
        fwd_b_i     = fb;
        rs1_data_i  = r1;
        rs2_data_i  = r2;
        imm_i       = im;
        reg_write_i = 1'b1;
    endtask

    // Issue an M op and follow it to capture, counting the cycles ready_o is low.
    task automatic runMop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_low);
        int low;
        int bad;
        low = 0;
        bad = 0;
        applyStimulus(1'b1, 2'b10, f3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, a, b, 32'h0);
        #1;
        while (ready_o === 1'b0 && low < 200) begin
            if (low > 0 && (valid_mem_o !== 1'b0 || reg_write_mem_o !== 1'b0)) bad++;
            low++;
            @(negedge clk_i);
            #1;
        end
        checkOutput({tag, "_ready_low_cycles"}, low, exp_low);
        checkOutput({tag, "_bubbles"}, bad, 0);
        @(negedge clk_i);
        checkOutput({tag, "_valid"}, valid_mem_o, 1'b1);
        checkOutput({tag, "_result"}, alu_result_mem_o, exp);
        checkOutput({tag, "_regwrite"}, reg_write_mem_o, 1'b1);
        valid_i = 1'b0;
    endtask

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        int bad;
        reset_ni = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        mem_to_reg_i = 1'b0;
        mem_write_i = 1'b0;
        mem_read_i = 1'b0;
        branch_i = 1'b0;
        pc_i = 32'h0000_1000;
        rd_i = 5'd5;
        wb_data_i = 32'h0;
        applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk_i);
        checkOutput("rst_valid", valid_mem_o, 1'b0);
        checkOutput("rst_result", alu_result_mem_o, 32'h0);
        checkOutput("rst_regwrite", reg_write_mem_o, 1'b0);
        checkOutput("rst_ready", ready_o, 1'b1);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd2, 32'd3, 32'h0);
        @(negedge clk_i);
        checkOutput("add_base", alu_result_mem_o, 32'd5);

        applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'd99, 32'd7, 32'h0);
        @(negedge clk_i);
        checkOutput("add_fwd_mem", alu_result_mem_o, 32'd12);
        checkOutput("add_fwd_valid", valid_mem_o, 1'b1);
        checkOutput("add_fwd_zero", zero_mem_o, 1'b0);

        applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd9, 32'd9, 32'h0);
        @(negedge clk_i);
        checkOutput("sub_result", alu_result_mem_o, 32'd0);
        checkOutput("sub_zero", zero_mem_o, 1'b1);

        applyStimulus(1'b1, 2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h8000_0010, 32'd4, 32'h0);
        @(negedge clk_i);
        checkOutput("sra", alu_result_mem_o, 32'hF800_0001);

        applyStimulus(1'b1, 2'b11, 3'b010, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        @(negedge clk_i);
        checkOutput("slti", alu_result_mem_o, 32'd0);

        applyStimulus(1'b1, 2'b11, 3'b011, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        @(negedge clk_i);
        checkOutput("sltiu", alu_result_mem_o, 32'd1);

        wb_data_i = 32'h0000_0100;
        applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 32'd1, 32'hDEAD, 32'h20);
        @(negedge clk_i);
        checkOutput("add_fwd_wb", alu_result_mem_o, 32'h101);
        checkOutput("store_fwd_wb", store_data_mem_o, 32'h100);
        checkOutput("pc_target", pc_target_mem_o, 32'h1020);

        applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1, 32'd1, 32'h0);
        @(negedge clk_i);
        checkOutput("invalid_valid", valid_mem_o, 1'b0);
        checkOutput("invalid_regwrite", reg_write_mem_o, 1'b0);

        runMop("mul", 3'b000, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFEE, 33);
        runMop("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runMop("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
        runMop("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        runMop("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        runMop("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        runMop("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        runMop("div_by0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        runMop("rem_by0", 3'b110, 32'd7, 32'd0, 32'd7, 1);
        runMop("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        runMop("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Flush during cycle 10 of a divide.
        applyStimulus(1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'd100, 32'd7, 32'h0);
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        checkOutput("flush_valid", valid_mem_o, 1'b0);
        checkOutput("flush_ready", ready_o, 1'b1);
        applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd2, 32'd3, 32'h0);
        @(negedge clk_i);
        checkOutput("flush_add", alu_result_mem_o, 32'd5);
        checkOutput("flush_add_valid", valid_mem_o, 1'b1);
        runMop("flush_then_div0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);

        // Stall raised mid-iteration and held for three cycles of DONE.
        applyStimulus(1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'd100, 32'd7, 32'h0);
        repeat (5) @(negedge clk_i);
        stall_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk_i);
            if (valid_mem_o !== 1'b0 || reg_write_mem_o !== 1'b0 || ready_o !== 1'b0) bad++;
        end
        checkOutput("stall_hold", bad, 0);
        stall_i = 1'b0;
        #1;
        checkOutput("stall_done_ready", ready_o, 1'b1);
        @(negedge clk_i);
        checkOutput("stall_capture_valid", valid_mem_o, 1'b1);
        checkOutput("stall_capture_result", alu_result_mem_o, 32'd14);
        valid_i = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        pc_i = 32'h0000_1000;
        applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h11, 32'h22, 32'h40);
        @(negedge clk_i);
        checkOutput("pre_rst_add", alu_result_mem_o, 32'h33);
        applyStimulus(1'b1, 2'b10, 3'b011, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h40);
        repeat (10) @(negedge clk_i);
        #2;
        reset_ni = 1'b0;
        #1;
        checkOutput("arst_result", alu_result_mem_o, 32'h0);
        checkOutput("arst_pc_target", pc_target_mem_o, 32'h0);
        checkOutput("arst_rd", rd_mem_o, 5'd0);
        checkOutput("arst_valid", valid_mem_o, 1'b0);
        valid_i = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("post_rst_valid", valid_mem_o, 1'b0);
        checkOutput("post_rst_result", alu_result_mem_o, 32'h0);
        runMop("mul_after_rst", 3'b000, 32'd6, 32'd7, 32'd42, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage with an iterative RV32M/RV64M multiply/divide unit, operand forwarding, and an EX/MEM pipeline register with stall, flush and valid handshake. It sits between the ID/EX register and the memory-access stage. Single-cycle ALU ops pass through in one cycle. M-extension ops hold the upstream pipeline through `ready_o` while a shared shift-add/restoring-divide datapath iterates. Ops with no operation perform no writes.

## Interface
- `XLEN`, 32: datapath width; 32 or 64.
- `REG_ADDR_W`, 5: register index width.

- `clk_i` in 1: clock.
- `reset_ni` in 1: asynchronous, active-low reset.
- `valid_i` in 1: ID/EX holds a live instruction.
- `ready_o` out 1: EX accepts the instruction this cycle; upstream holds when low.
- `stall_i` in 1: MEM cannot accept; EX/MEM register holds.
- `flush_i` in 1: kill the instruction in EX, including any in-flight M op.
- `mem_to_reg_i`, `mem_write_i`, `mem_read_i`, `reg_write_i`, `branch_i`, `alu_src_i` in 1 each: control signals.
- `alu_op_i` in 2: 00 add, 01 sub/branch, 10 R-type, 11 I-type ALU.
- `funct3_i` in 3; `funct7_b5_i` in 1; `funct7_b0_i` in 1: `funct7_b0_i`=1 with R-type selects an M op.
- `pc_i`, `rs1_data_i`, `rs2_data_i`, `imm_i` in XLEN.
- `rd_i` in REG_ADDR_W.
- `fwd_a_i`, `fwd_b_i` in 2: 00 regfile, 01 `alu_result_mem_o`, 10 `wb_data_i`, 11 same as 00.
- `wb_data_i` in XLEN: writeback-stage result.
- `valid_mem_o` out 1.
- `alu_result_mem_o`, `pc_target_mem_o`, `store_data_mem_o` out XLEN.
- `zero_mem_o` out 1.
- `rd_mem_o` out REG_ADDR_W.
- `mem_to_reg_mem_o`, `mem_write_mem_o`, `mem_read_mem_o`, `reg_write_mem_o`, `branch_mem_o` out 1 each.

## Operation
- Operand A = forward mux A.
- Operand B = `imm_i` if `alu_src_i`, else forward mux B.
- `store_data_mem_o` captures forwarded rs2, not raw rs2.
- `pc_target` = `pc_i + imm_i`, modulo 2^XLEN.
- Zero flag = (ALU result == 0).
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount = low log2(XLEN) bits of B.
- M ops, selected by funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Signed ops iterate on magnitudes and sign-correct the result.
  - The 2·XLEN product is kept internally; MUL returns the low half, MULH* the high half.
- Divide special cases resolve without iterating:
  - By zero: quotient all ones, remainder = dividend.
  - Signed overflow (min / −1): quotient = min, remainder = 0.
- FSM `md_state`:
  - IDLE: M op with `valid_i` and not `flush_i` → latch operands and op, counter = XLEN−1, go to BUSY. A special-case divide goes straight to DONE.
  - BUSY: one iteration per cycle, counter decrements. Counter==0 → DONE.
  - DONE: result is presented. When `!stall_i`, the result is captured into EX/MEM and the FSM goes to IDLE. Otherwise it stays in DONE.
  - `flush_i` in any state → IDLE.
- `ready_o` = `!stall_i && !(valid_i && is_m && state != DONE)`.
- EX/MEM register update:
  - Priority is reset > flush > stall > load.
  - Flush: `valid_mem_o` and all write/read/branch controls go to 0.
  - Stall: every field holds.
  - `ready_o`=1: load the instruction; `valid_mem_o` = `valid_i`.
  - `ready_o`=0 and no stall: load a bubble (valid and controls 0, data fields don't-care).
- Bubbles, flushed slots and invalid slots never assert `reg_write`, `mem_write`, `mem_read` or `branch`.

## Timing
- Reset (async assert, sync deassert at the top level):
  - FSM goes to IDLE and the counter to 0.
  - Every EX/MEM output goes to 0.
  - `ready_o` then follows its combinational equation.
- ALU op latency: result visible at `*_mem_o` one edge after acceptance.
- M op latency:
  - Presented at cycle 0; `ready_o` low in cycles 0..XLEN.
  - Captured at edge XLEN+2 (34 for XLEN=32).
  - Special-case divide: captured at edge 2.
- Operands are latched at the IDLE→BUSY edge. Later changes to the forwarding sources during the stall have no effect.
- Flush in the same cycle as DONE wins: the result is discarded.
- Stall during BUSY: iteration continues and the FSM waits in DONE.
- Reset mid-BUSY: the op is abandoned and no result appears.

## Structure
- Package `execute_pkg`:
  - `alu_ctrl_e`, `md_op_e`, `fwd_sel_e`, `md_state_e`.
  - Default `XLEN`.
- Sub-module `muldiv_iter`:
  - Contains the FSM, counter, operand latches and shift-add/restoring-divide datapath.
  - Interface: `start`, `op`, `a`, `b`, `flush`, `hold` → `busy`, `done`, `result`.
- Top level contains the ALU, ALU decode, forward muxes, PC adder and EX/MEM register.

## Test plan
- ADD with `fwd_a_i`=01 (`alu_result_mem_o`=5), rs2=7 → `alu_result_mem_o`=12, `valid_mem_o`=1, `zero_mem_o`=0 after 1 edge.
- MUL 6 × 0xFFFFFFFD → `ready_o` low 33 cycles, `valid_mem_o`=0 bubbles, then 0xFFFFFFEE captured at edge 34. MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU → 2. DIV 7/0 → 0xFFFFFFFF in 2 cycles; REM 7/0 → 7. DIV 0x80000000/−1 → 0x80000000; REM → 0.
- `flush_i` at cycle 10 of a DIV → IDLE next cycle, `valid_mem_o`=0, `ready_o`=1; a following ADD completes in 1 cycle.
- `stall_i` high across DONE for 3 cycles → EX/MEM fields hold, FSM stays in DONE, result captured on the first edge after `stall_i` falls.
- `reset_ni` low mid-BUSY, asynchronous with no clock edge → all outputs 0 immediately; after release, a new MUL gives the correct result.
